// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default widths,
// wait length and requester port indices.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int AW_DEF       = 8;
  localparam int DW_DEF       = 8;
  localparam int WAIT_CYC_DEF = 1;

  // Wide enough for WAIT_CYC up to 15
  localparam int CNT_W = 4;

  localparam logic P_CPU = 1'b0;
  localparam logic P_AUX = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. With DMEM_ARB_LOCK_EN defined, a held lock keeps
// the grant on the last-served port for as long as that port keeps requesting.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
`ifdef DMEM_ARB_LOCK_EN
  input  logic lock_hold,
`endif
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = P_CPU;
    if (req0 && req1) begin
      gnt_id = ~last;
    end else if (req1) begin
      gnt_id = P_AUX;
    end
`ifdef DMEM_ARB_LOCK_EN
    // The lock owner is always the last-served port
    if (lock_hold && (last ? req1 : req0)) begin
      gnt_id = last;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the shared data memory.
// Optional atomic lock support is enabled with the DMEM_ARB_LOCK_EN macro.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic          busy,
  output logic          gnt_id
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [AW-1:0]     mem_addr_reg, mem_addr_next;
  logic [DW-1:0]     mem_wdata_reg, mem_wdata_next;
  logic [DW-1:0]     rdata_reg, rdata_next;
  logic              we_reg, we_next;
  logic              gnt_id_reg, gnt_id_next;
  logic              last_reg, last_next;
  logic              arb_valid, arb_id;
`ifdef DMEM_ARB_LOCK_EN
  logic              lock_reg, lock_next;
`endif

  rr_arb2 u_rr_arb2 (
    .req0      (req0),
    .req1      (req1),
    .last      (last_reg),
`ifdef DMEM_ARB_LOCK_EN
    .lock_hold (lock_reg),
`endif
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rdata_reg     <= '0;
      we_reg        <= 1'b0;
      gnt_id_reg    <= P_CPU;
      last_reg      <= P_AUX;
`ifdef DMEM_ARB_LOCK_EN
      lock_reg      <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rdata_reg     <= rdata_next;
      we_reg        <= we_next;
      gnt_id_reg    <= gnt_id_next;
      last_reg      <= last_next;
`ifdef DMEM_ARB_LOCK_EN
      lock_reg      <= lock_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rdata_next     = rdata_reg;
    we_next        = we_reg;
    gnt_id_next    = gnt_id_reg;
    last_next      = last_reg;
`ifdef DMEM_ARB_LOCK_EN
    lock_next      = lock_reg;
`endif
    case (state_reg)
      IDLE: begin
`ifdef DMEM_ARB_LOCK_EN
        // An owner that stops requesting gives the lock up immediately
        if (lock_reg && !(last_reg ? req1 : req0)) begin
          lock_next = 1'b0;
        end
`endif
        if (arb_valid) begin
          state_next  = ACCESS;
          cnt_next    = CNT_W'(WAIT_CYC - 1);
          gnt_id_next = arb_id;
          if (arb_id == P_AUX) begin
            mem_addr_next  = addr1;
            mem_wdata_next = wdata1;
            we_next        = we1;
          end else begin
            mem_addr_next  = addr0;
            mem_wdata_next = wdata0;
            we_next        = we0;
          end
        end
      end
      ACCESS: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
          if (!we_reg) begin
            rdata_next = mem_rdata;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        last_next  = gnt_id_reg;
`ifdef DMEM_ARB_LOCK_EN
        lock_next  = (gnt_id_reg == P_AUX) ? lock1 : lock0;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes and acks decode directly from registered state, so they cannot overlap
  assign mem_read  = (state_reg == ACCESS) && !we_reg;
  assign mem_write = (state_reg == ACCESS) && we_reg;
  assign ack0      = (state_reg == DONE) && (gnt_id_reg == P_CPU);
  assign ack1      = (state_reg == DONE) && (gnt_id_reg == P_AUX);
  assign busy      = (state_reg != IDLE);
  assign gnt_id    = gnt_id_reg;
  assign rdata     = rdata_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 uses WAIT_CYC=1, instance 1 WAIT_CYC=3.
// A transaction-level model is compared every cycle; directed tests pin it with literals.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic mem_clear;

  logic       req0_s[2], we0_s[2], req1_s[2], we1_s[2], lock0_s[2], lock1_s[2];
  logic [7:0] addr0_s[2], wdata0_s[2], addr1_s[2], wdata1_s[2];
  logic       ack0_s[2], ack1_s[2], mem_read_s[2], mem_write_s[2], busy_s[2], gnt_s[2];
  logic [7:0] rdata_s[2], maddr_s[2], mwdata_s[2], mrdata_s[2];

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [7:0] a);
    return (a == 8'h10) ? 8'h5A : (a ^ 8'hC3);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    logic [7:0] mem [256];
    logic [1:0] scnt;

    dmem_arbiter #(.AW(8), .DW(8), .WAIT_CYC(gi == 0 ? 1 : 3)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0_s[gi]),
      .we0       (we0_s[gi]),
      .addr0     (addr0_s[gi]),
      .wdata0    (wdata0_s[gi]),
      .ack0      (ack0_s[gi]),
      .req1      (req1_s[gi]),
      .we1       (we1_s[gi]),
      .addr1     (addr1_s[gi]),
      .wdata1    (wdata1_s[gi]),
      .ack1      (ack1_s[gi]),
`ifdef DMEM_ARB_LOCK_EN
      .lock0     (lock0_s[gi]),
      .lock1     (lock1_s[gi]),
`endif
      .rdata     (rdata_s[gi]),
      .mem_addr  (maddr_s[gi]),
      .mem_wdata (mwdata_s[gi]),
      .mem_rdata (mrdata_s[gi]),
      .mem_read  (mem_read_s[gi]),
      .mem_write (mem_write_s[gi]),
      .busy      (busy_s[gi]),
      .gnt_id    (gnt_s[gi])
    );

    // Read data is tagged with the strobe cycle index so the capture cycle is visible
    assign mrdata_s[gi] = mem[maddr_s[gi]] ^ {6'd0, scnt};

    always @(posedge clk) begin
      if (mem_clear) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_byte(8'(i));
      end else if (mem_write_s[gi]) begin
        mem[maddr_s[gi]] <= mwdata_s[gi];
      end
      scnt <= mem_read_s[gi] ? scnt + 2'd1 : 2'd0;
    end
  end

  // Model: m_rem counts the cycles left in the current access (W strobe cycles, then ack)
  int       m_rem[2];
  bit       m_we[2], m_last[2], m_gnt[2], m_lock[2];
  bit [7:0] m_addr[2], m_wdata[2], m_rdata[2];
  bit [7:0] m_mem[2][256];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int w;
      bit own_req, win;
      w = (k == 0) ? 1 : 3;
      if (mem_clear) for (int i = 0; i < 256; i++) m_mem[k][i] = init_byte(8'(i));
      if (m_rem[k] >= 2 && m_we[k]) m_mem[k][m_addr[k]] = m_wdata[k];
      if (reset) begin
        m_rem[k] = 0; m_last[k] = 1; m_rdata[k] = 0; m_gnt[k] = 0; m_lock[k] = 0;
      end else if (m_rem[k] == 1) begin
        m_last[k] = m_gnt[k];
        m_lock[k] = m_gnt[k] ? lock1_s[k] : lock0_s[k];
        m_rem[k]  = 0;
      end else if (m_rem[k] >= 2) begin
        if (m_rem[k] == 2 && !m_we[k]) m_rdata[k] = m_mem[k][m_addr[k]] ^ 8'(w - 1);
        m_rem[k]--;
      end else begin
        own_req = m_last[k] ? req1_s[k] : req0_s[k];
        if (m_lock[k] && !own_req) m_lock[k] = 0;
        if (req0_s[k] || req1_s[k]) begin
          if (m_lock[k]) win = m_last[k];
          else if (req0_s[k] && req1_s[k]) win = !m_last[k];
          else win = req1_s[k];
          m_gnt[k]   = win;
          m_we[k]    = win ? we1_s[k] : we0_s[k];
          m_addr[k]  = win ? addr1_s[k] : addr0_s[k];
          m_wdata[k] = win ? wdata1_s[k] : wdata0_s[k];
          m_rem[k]   = w + 1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[inst%0d] t=%0t got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic compare_step();
    for (int k = 0; k < 2; k++) begin
      bit strobe;
      strobe = (m_rem[k] >= 2);
      chk("busy",      k, busy_s[k],      m_rem[k] != 0);
      chk("mem_read",  k, mem_read_s[k],  strobe && !m_we[k]);
      chk("mem_write", k, mem_write_s[k], strobe && m_we[k]);
      chk("ack0",      k, ack0_s[k],      m_rem[k] == 1 && !m_gnt[k]);
      chk("ack1",      k, ack1_s[k],      m_rem[k] == 1 && m_gnt[k]);
      chk("gnt_id",    k, gnt_s[k],       m_gnt[k]);
      chk("rdata",     k, rdata_s[k],     m_rdata[k]);
      if (strobe) chk("mem_addr", k, maddr_s[k], m_addr[k]);
      if (strobe && m_we[k]) chk("mem_wdata", k, mwdata_s[k], m_wdata[k]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) compare_step();
  end

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      req0_s[k] = 0; we0_s[k] = 0; addr0_s[k] = 0; wdata0_s[k] = 0; lock0_s[k] = 0;
      req1_s[k] = 0; we1_s[k] = 0; addr1_s[k] = 0; wdata1_s[k] = 0; lock1_s[k] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    clear_inputs();
    @(negedge clk);
    reset = 0;
  endtask

  // One access on instance k, port p; checks ack latency and strobe length
  task automatic access(input int k, input bit p, input bit we, input bit [7:0] a,
                        input bit [7:0] d, input int w, output bit [7:0] rd);
    int n, nstb;
    bit got;
    @(negedge clk);
    if (p) begin req1_s[k] = 1; we1_s[k] = we; addr1_s[k] = a; wdata1_s[k] = d; end
    else   begin req0_s[k] = 1; we0_s[k] = we; addr0_s[k] = a; wdata0_s[k] = d; end
    n = 0; nstb = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_read_s[k] || mem_write_s[k]) nstb++;
      got = p ? ack1_s[k] : ack0_s[k];
    end
    chk("ack_latency", k, n, w + 1);
    chk("strobe_cycles", k, nstb, w);
    rd = rdata_s[k];
    req0_s[k] = 0; req1_s[k] = 0;
  endtask

  initial begin
    bit [7:0] rd;
    int t[4];
    bit id[4];
    int na, n;

    reset = 1; mem_clear = 1;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    started = 1;
    chk("reset_busy", 0, busy_s[0], 0);
    chk("reset_gnt", 0, gnt_s[0], 0);
    chk("reset_rdata", 1, rdata_s[1], 0);
    reset = 0; mem_clear = 0;

    // Single read, WAIT_CYC=1
    access(0, 0, 0, 8'h10, 8'h00, 1, rd);
    chk("t1_rdata", 0, rd, 8'h5A);
    $display("single read      inst0 addr=10 rdata=%02h", rd);

    // Port 1 write then port 0 read-back
    access(0, 1, 1, 8'h3C, 8'hA5, 1, rd);
    chk("t2_mem", 0, g_inst[0].mem[8'h3C], 8'hA5);
    $display("write            inst0 addr=3c wdata=a5 via port1");
    access(0, 0, 0, 8'h3C, 8'h00, 1, rd);
    chk("t2_rdata", 0, rd, 8'hA5);
    $display("read back        inst0 addr=3c rdata=%02h", rd);

    // WAIT_CYC=3: captured in the third strobe cycle (tag 2)
    access(1, 0, 0, 8'h10, 8'h00, 3, rd);
    chk("t4_rdata", 1, rd, 8'h58);
    $display("single read      inst1 addr=10 rdata=%02h", rd);

    // Contention from reset release
    do_reset();
    req0_s[0] = 1; addr0_s[0] = 8'h20; req1_s[0] = 1; addr1_s[0] = 8'h21;
    na = 0; n = 0;
    while (na < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (ack0_s[0] || ack1_s[0]) begin
        t[na] = n; id[na] = ack1_s[0]; na++;
      end
    end
    req0_s[0] = 0; req1_s[0] = 0;
    chk("t3_ack_count", 0, na, 4);
    for (int i = 0; i < na; i++) begin
      chk("t3_order", 0, id[i], i % 2);
      chk("t3_ack_cycle", 0, t[i], 2 + 3 * i);
      $display("contention       inst0 ack port%0d at cycle %0d", id[i], t[i]);
    end

    // Reset during the first ACCESS cycle of a write
    @(negedge clk);
    req1_s[0] = 1; we1_s[0] = 1; addr1_s[0] = 8'h44; wdata1_s[0] = 8'h77;
    @(negedge clk);
    chk("t5_write_strobe", 0, mem_write_s[0], 1);
    reset = 1;
    @(negedge clk);
    chk("t5_strobe_off", 0, mem_write_s[0], 0);
    chk("t5_busy", 0, busy_s[0], 0);
    chk("t5_no_ack", 0, ack1_s[0], 0);
    reset = 0;
    we1_s[0] = 0; req0_s[0] = 1; addr0_s[0] = 8'h44;
    @(negedge clk);
    chk("t5_tie_gnt", 0, gnt_s[0], 0);
    $display("reset mid-access inst0 next tie granted port%0d", gnt_s[0]);
    n = 0;
    while (!ack0_s[0] && n < 40) begin @(negedge clk); n++; end
    chk("t5_ack0_seen", 0, ack0_s[0], 1);
    req0_s[0] = 0;
    n = 0;
    while (!ack1_s[0] && n < 40) begin @(negedge clk); n++; end
    chk("t5_ack1_seen", 0, ack1_s[0], 1);
    req1_s[0] = 0;

`ifdef DMEM_ARB_LOCK_EN
    // Port 1 holds the lock across two accesses while port 0 waits
    do_reset();
    req1_s[0] = 1; lock1_s[0] = 1; addr1_s[0] = 8'h50;
    @(negedge clk);
    req0_s[0] = 1; addr0_s[0] = 8'h51;
    na = 0; n = 0;
    while (na < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (na == 1 && !(ack0_s[0] || ack1_s[0])) lock1_s[0] = 0;
      if (ack0_s[0] || ack1_s[0]) begin
        id[na] = ack1_s[0]; na++;
        if (na == 2) req1_s[0] = 0;
        if (na == 3) req0_s[0] = 0;
      end
    end
    chk("t6_ack_count", 0, na, 3);
    chk("t6_order0", 0, id[0], 1);
    chk("t6_order1", 0, id[1], 1);
    chk("t6_order2", 0, id[2], 0);
    $display("lock             inst0 order %0d %0d %0d", id[0], id[1], id[2]);
    req0_s[0] = 0; req1_s[0] = 0;
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
